// File: rtl/clk_gate_pkg.sv
// Shared types for the mainband clock-gate sequencer: FSM encoding,
// requester indices and the counter width helper.
package clk_gate_pkg;

  typedef enum logic [2:0] {
    GATED   = 3'd0,
    SETTLE  = 3'd1,
    WAIT_UP = 3'd2,
    ACTIVE  = 3'd3,
    IDLE    = 3'd4,
    WAIT_DN = 3'd5
  } cg_state_e;

  localparam int REQ_ADAPTER  = 0;
  localparam int REQ_SB_MSG   = 1;
  localparam int REQ_SB_TRAIN = 2;

  // One counter serves every timed phase, so size it for the longest one.
  function automatic int cnt_width(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/cg_down_counter.sv
// Loadable down-counter that holds at zero; zero flag drives phase exits.
module cg_down_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         zero
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     cnt <= '0;
    else if (load)  cnt <= load_val;
    else if (!zero) cnt <= cnt - 1'b1;
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/clk_gate_sequencer.sv
// RDI mainband clock-gate sequencer: wake arbitration, settle/ack handshake,
// idle-qualified gating, timeout supervision. Debug ports under CLK_GATE_DBG_EN.
module clk_gate_sequencer
  import clk_gate_pkg::*;
#(
  parameter int NUM_REQ       = 3,
  parameter int SETTLE_CYCLES = 8,
  parameter int IDLE_CYCLES   = 16,
  parameter int ACK_TIMEOUT   = 256
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic [NUM_REQ-1:0] i_wake_req,
  input  logic               i_gate_req,
  input  logic               i_clk_ungated_ack,
  output logic               o_clk_gate_en,
  output logic [NUM_REQ-1:0] o_wake_ack,
  output logic               o_busy,
  output logic               o_timeout_err
`ifdef CLK_GATE_DBG_EN
  ,
  output logic [2:0]         o_dbg_state,
  output logic [7:0]         o_dbg_timeout_cnt
`endif
);

  localparam int CNT_W = cnt_width(SETTLE_CYCLES, IDLE_CYCLES, ACK_TIMEOUT);
  localparam logic [CNT_W-1:0] SETTLE_LD = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] IDLE_LD   = CNT_W'(IDLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] TMO_LD    = CNT_W'(ACK_TIMEOUT - 1);

  cg_state_e          state, nxt;
  logic               cnt_load, cnt_zero;
  logic [CNT_W-1:0]   cnt_ld_val;
  logic               en_d, tmo_d;
  logic [NUM_REQ-1:0] ack_d;
  logic               any_req;

  assign any_req = |i_wake_req;

  cg_down_counter #(.W(CNT_W)) u_cnt (
    .clk      (i_clk),
    .rst_n    (i_rst_n),
    .load     (cnt_load),
    .load_val (cnt_ld_val),
    .zero     (cnt_zero)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state         <= GATED;
      o_clk_gate_en <= 1'b0;
      o_wake_ack    <= '0;
      o_timeout_err <= 1'b0;
    end else begin
      state         <= nxt;
      o_clk_gate_en <= en_d;
      o_wake_ack    <= ack_d;
      o_timeout_err <= tmo_d;
    end
  end

  always_comb begin
    nxt = state;
    unique case (state)
      GATED:   if (any_req) nxt = SETTLE;
      SETTLE:  if (cnt_zero) nxt = WAIT_UP;
      WAIT_UP: if (i_clk_ungated_ack) nxt = ACTIVE;
               else if (cnt_zero)     nxt = GATED;
      // A wake in the same cycle as the gate request keeps us ACTIVE.
      ACTIVE:  if (i_gate_req && !any_req && ~|o_wake_ack) nxt = IDLE;
      IDLE:    if (any_req || !i_gate_req) nxt = ACTIVE;
               else if (cnt_zero)         nxt = WAIT_DN;
      // Wakes seen here wait for GATED so the enable never glitches high.
      WAIT_DN: if (!i_clk_ungated_ack || cnt_zero) nxt = GATED;
      default: nxt = GATED;
    endcase
    cnt_load   = (nxt != state);
    cnt_ld_val = '0;
    case (nxt)
      SETTLE:           cnt_ld_val = SETTLE_LD;
      IDLE:             cnt_ld_val = IDLE_LD;
      WAIT_UP, WAIT_DN: cnt_ld_val = TMO_LD;
      default:          cnt_ld_val = '0;
    endcase
  end

  always_comb begin
    en_d   = nxt inside {SETTLE, WAIT_UP, ACTIVE, IDLE};
    ack_d  = (state == ACTIVE) ? i_wake_req : '0;
    tmo_d  = cnt_zero && ((state == WAIT_UP && !i_clk_ungated_ack) ||
                          (state == WAIT_DN &&  i_clk_ungated_ack));
    o_busy = state inside {SETTLE, WAIT_UP, IDLE, WAIT_DN};
  end

`ifdef CLK_GATE_DBG_EN
  assign o_dbg_state = state;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)                           o_dbg_timeout_cnt <= '0;
    else if (tmo_d && o_dbg_timeout_cnt != 8'hFF) o_dbg_timeout_cnt <= o_dbg_timeout_cnt + 8'd1;
  end
`endif

endmodule

// File: tb/tb_clk_gate_sequencer.sv
// Bench for clk_gate_sequencer: phase/elapsed-time model checked every cycle
// plus directed scenarios with hand-computed cycle expectations.
module tb_clk_gate_sequencer;

  localparam int NUM_REQ = 3;
  localparam int SETTLE  = 8;
  localparam int IDLE_N  = 16;
  localparam int TMO     = 256;

  logic               i_clk = 1'b0;
  logic               i_rst_n = 1'b0;
  logic [NUM_REQ-1:0] i_wake_req = '0;
  logic               i_gate_req = 1'b0;
  logic               i_clk_ungated_ack = 1'b0;
  logic               o_clk_gate_en;
  logic [NUM_REQ-1:0] o_wake_ack;
  logic               o_busy;
  logic               o_timeout_err;
`ifdef CLK_GATE_DBG_EN
  logic [2:0]         o_dbg_state;
  logic [7:0]         o_dbg_timeout_cnt;
`endif

  clk_gate_sequencer #(
    .NUM_REQ(NUM_REQ), .SETTLE_CYCLES(SETTLE), .IDLE_CYCLES(IDLE_N), .ACK_TIMEOUT(TMO)
  ) dut (
    .i_clk             (i_clk),
    .i_rst_n           (i_rst_n),
    .i_wake_req        (i_wake_req),
    .i_gate_req        (i_gate_req),
    .i_clk_ungated_ack (i_clk_ungated_ack),
    .o_clk_gate_en     (o_clk_gate_en),
    .o_wake_ack        (o_wake_ack),
    .o_busy            (o_busy),
    .o_timeout_err     (o_timeout_err)
`ifdef CLK_GATE_DBG_EN
    ,
    .o_dbg_state       (o_dbg_state),
    .o_dbg_timeout_cnt (o_dbg_timeout_cnt)
`endif
  );

  always #5 i_clk = ~i_clk;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
  endtask

  // Model: which phase the link is in and how long it has been there.
  typedef enum {M_OFF, M_RAMP, M_UP, M_ON, M_COOL, M_DN} mph_e;
  mph_e               ph = M_OFF;
  int                 t = 0;
  logic               e_en = 1'b0, e_tmo = 1'b0;
  logic [NUM_REQ-1:0] e_ack = '0;
  int                 e_tcnt = 0;

  always @(posedge i_clk or negedge i_rst_n) begin
    mph_e np;
    int   tc;
    if (!i_rst_n) begin
      ph = M_OFF; t = 0; e_en = 0; e_tmo = 0; e_ack = '0; e_tcnt = 0;
    end else begin
      np = ph; tc = t + 1; e_tmo = 0;
      case (ph)
        M_OFF:  if (i_wake_req != 0) np = M_RAMP;
        M_RAMP: if (tc >= SETTLE) np = M_UP;
        M_UP:   if (i_clk_ungated_ack) np = M_ON;
                else if (tc >= TMO) begin np = M_OFF; e_tmo = 1; end
        M_ON:   if (i_gate_req && i_wake_req == 0 && e_ack == 0) np = M_COOL;
        M_COOL: if (i_wake_req != 0 || !i_gate_req) np = M_ON;
                else if (tc >= IDLE_N) np = M_DN;
        M_DN:   if (!i_clk_ungated_ack) np = M_OFF;
                else if (tc >= TMO) begin np = M_OFF; e_tmo = 1; end
        default: np = M_OFF;
      endcase
      e_ack = (ph == M_ON) ? i_wake_req : '0;
      if (e_tmo && e_tcnt < 255) e_tcnt++;
      t = (np == ph) ? tc : 0;
      ph = np;
      e_en = (ph == M_RAMP || ph == M_UP || ph == M_ON || ph == M_COOL);
    end
  end

  function automatic int ph_code(input mph_e p);
    case (p)
      M_OFF: return 0; M_RAMP: return 1; M_UP: return 2;
      M_ON:  return 3; M_COOL: return 4; default: return 5;
    endcase
  endfunction

  bit run = 0;
  always @(negedge i_clk) begin
    if (i_rst_n && run) begin
      chk("cyc_en",   int'(o_clk_gate_en), int'(e_en));
      chk("cyc_ack",  int'(o_wake_ack),    int'(e_ack));
      chk("cyc_busy", int'(o_busy),        int'(ph == M_RAMP || ph == M_UP || ph == M_COOL || ph == M_DN));
      chk("cyc_tmo",  int'(o_timeout_err), int'(e_tmo));
`ifdef CLK_GATE_DBG_EN
      chk("cyc_dbg_state", int'(o_dbg_state),       ph_code(ph));
      chk("cyc_dbg_tcnt",  int'(o_dbg_timeout_cnt), e_tcnt);
`endif
    end
  end

  // MB-domain stand-in: ack follows the enable three cycles later.
  logic [2:0] ack_sh = '0;
  bit         ack_auto = 1;

  task automatic step(input int n);
    repeat (n) begin
      @(negedge i_clk);
      ack_sh = {ack_sh[1:0], o_clk_gate_en};
      if (ack_auto) i_clk_ungated_ack = ack_sh[2];
    end
  endtask

  initial begin
    step(3);
    chk("rst_en",   int'(o_clk_gate_en), 0);
    chk("rst_ack",  int'(o_wake_ack),    0);
    chk("rst_busy", int'(o_busy),        0);
    chk("rst_tmo",  int'(o_timeout_err), 0);
    i_rst_n = 1; run = 1;
    step(1);
    chk("idle_en", int'(o_clk_gate_en), 0);

    // Wake from adapter
    i_wake_req = 3'b001;
    step(1);  chk("w1_en_c1", int'(o_clk_gate_en), 1); chk("w1_busy_c1", int'(o_busy), 1);
    step(9);  chk("w1_busy_c10", int'(o_busy), 0);     chk("w1_ack_c10", int'(o_wake_ack), 0);
    step(1);  chk("w1_ack_c11", int'(o_wake_ack), 1);
    i_wake_req = 3'b000;
    step(1);  chk("w1_ack_drop", int'(o_wake_ack), 0);

    // Gate after 16 idle cycles
    i_gate_req = 1;
    step(16); chk("g_en_c16", int'(o_clk_gate_en), 1); chk("g_busy_c16", int'(o_busy), 1);
    step(1);  chk("g_en_c17", int'(o_clk_gate_en), 0);
    step(2);  chk("g_busy_c19", int'(o_busy), 1);
    step(1);  chk("g_busy_c20", int'(o_busy), 0);      chk("g_en_c20", int'(o_clk_gate_en), 0);

    // Abort IDLE at count 5 with a sideband message wake
    i_gate_req = 0; i_wake_req = 3'b010;
    step(12); chk("sb_ack", int'(o_wake_ack), 2);
    i_wake_req = 3'b000;
    step(2);
    i_gate_req = 1;
    step(11); chk("ab_busy", int'(o_busy), 1);
    i_wake_req = 3'b010;
    step(3);  chk("ab_ack", int'(o_wake_ack), 2); chk("ab_en", int'(o_clk_gate_en), 1);
              chk("ab_busy2", int'(o_busy), 0);
    i_wake_req = 3'b000;
    step(25); chk("ab_gated_busy", int'(o_busy), 0); chk("ab_gated_en", int'(o_clk_gate_en), 0);

    // WAIT_UP timeout with the ack held low
    i_gate_req = 0; ack_auto = 0; i_clk_ungated_ack = 0; i_wake_req = 3'b100;
    step(264); chk("to_tmo_pre", int'(o_timeout_err), 0); chk("to_en_pre", int'(o_clk_gate_en), 1);
    step(1);   chk("to_tmo", int'(o_timeout_err), 1);     chk("to_en", int'(o_clk_gate_en), 0);
               chk("to_busy", int'(o_busy), 0);
`ifdef CLK_GATE_DBG_EN
               chk("to_dbg_cnt", int'(o_dbg_timeout_cnt), 1);
`endif
    step(1);   chk("to_tmo_post", int'(o_timeout_err), 0); chk("to_retry_en", int'(o_clk_gate_en), 1);
    ack_auto = 1; i_wake_req = 3'b000;
    step(14);  chk("to_active_busy", int'(o_busy), 0);     chk("to_active_en", int'(o_clk_gate_en), 1);

    // Wake arriving during WAIT_DN
    i_gate_req = 1;
    step(17); chk("wd_en_c17", int'(o_clk_gate_en), 0);
    i_wake_req = 3'b001;
    step(1);  chk("wd_en_c18", int'(o_clk_gate_en), 0); chk("wd_busy_c18", int'(o_busy), 1);
    step(2);  chk("wd_en_c20", int'(o_clk_gate_en), 0); chk("wd_busy_c20", int'(o_busy), 0);
    step(1);  chk("wd_en_c21", int'(o_clk_gate_en), 1);
    step(11); chk("wd_ack", int'(o_wake_ack), 1);

    // Async reset while ACTIVE
    #3 i_rst_n = 0;
    #1;
    chk("ar_en",   int'(o_clk_gate_en), 0);
    chk("ar_ack",  int'(o_wake_ack),    0);
    chk("ar_busy", int'(o_busy),        0);
    i_wake_req = 3'b000; i_gate_req = 0;
    step(2);
    i_rst_n = 1;
    step(3);
    chk("ar_post_en", int'(o_clk_gate_en), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/clk_gate_sequencer.md
Name: clk_gate_sequencer

Overview:
- Sequences mainband clock gating for the RDI.
- Arbitrates wake requests from three sources (adapter wake, sideband message, sideband start-training) onto one gate-enable resource.
- Waits a settle period and a synchronized ungate acknowledge before granting per-requester wake acks.
- Gates the clock only after a qualified idle period, and supervises both handshake directions with a timeout.

Parameters:
- NUM_REQ, 3: number of wake requesters. Bit 0 is adapter, bit 1 is sideband message, bit 2 is sideband start-training.
- SETTLE_CYCLES, 8: cycles between gate-enable rise and start of ack wait. Legal range is 1 or more.
- IDLE_CYCLES, 16: cycles of held gate request with no wake request before gating. Legal range is 1 or more.
- ACK_TIMEOUT, 256: maximum cycles to wait for the ungate-ack edge in either direction.

Ports:
- i_clk, input, 1: single clock.
- i_rst_n, input, 1: asynchronous active-low reset.
- i_wake_req, input, NUM_REQ: level wake requests, one bit per requester.
- i_gate_req, input, 1: level gating request from the RDI FSM (L1/L2/LinkReset/Disabled/Reset-idle).
- i_clk_ungated_ack, input, 1: already-synchronized return of the gate enable from the MB clock domain.
- o_clk_gate_en, output, 1: registered clock enable; 1 means ungated.
- o_wake_ack, output, NUM_REQ: registered per-requester 4-phase ack.
- o_busy, output, 1: high in any transitional state.
- o_timeout_err, output, 1: one-cycle pulse on handshake timeout.

Behaviour:
- Reset (async, active-low): state GATED; counter 0; all outputs 0. Reset mid-operation drops o_clk_gate_en immediately, with no handshake.
- Counter: one shared down-counter, width $clog2(max(SETTLE_CYCLES, IDLE_CYCLES, ACK_TIMEOUT)+1). It is loaded on state entry, decrements every cycle, and saturates at 0.
- GATED: o_clk_gate_en=0. If |i_wake_req, go to SETTLE and load SETTLE_CYCLES-1; o_clk_gate_en rises in that cycle's register update.
- SETTLE: o_clk_gate_en=1. When the counter reaches 0, go to WAIT_UP and load ACK_TIMEOUT-1.
- WAIT_UP: if i_clk_ungated_ack=1, go to ACTIVE. If the counter reaches 0 first, pulse o_timeout_err and go to GATED (o_clk_gate_en=0). A still-pending request retries from GATED on the next cycle.
- ACTIVE:
  - o_clk_gate_en=1.
  - Each cycle, o_wake_ack[i] <= i_wake_req[i] (4-phase: ack rises one cycle after req while ACTIVE and falls one cycle after req falls).
  - If i_gate_req & ~|i_wake_req & ~|o_wake_ack, go to IDLE and load IDLE_CYCLES-1.
  - A wake request in the same cycle as the gate request wins, and the block stays ACTIVE.
- IDLE: o_clk_gate_en=1.
  - Any wake request, or i_gate_req falling, aborts to ACTIVE.
  - When the counter reaches 0, go to WAIT_DN, drop o_clk_gate_en, and load ACK_TIMEOUT-1.
- WAIT_DN:
  - If i_clk_ungated_ack=0, go to GATED.
  - Wake requests arriving here are not serviced until GATED is reached, so there is no enable glitch; the block then re-ungates normally.
  - If the counter reaches 0 first, pulse o_timeout_err and go to GATED anyway.
- Acks are 0 in every state except ACTIVE.
- o_busy=1 in SETTLE, WAIT_UP, IDLE and WAIT_DN.
- o_timeout_err is exactly one cycle wide per timeout event.

Optional Feature:
- Macro CLK_GATE_DBG_EN defined: adds two outputs.
  - o_dbg_state [2:0]: current state encoding.
  - o_dbg_timeout_cnt [7:0]: saturating count of timeout events, cleared only by reset.
- Macro undefined: these ports and their logic are absent; all other behaviour is identical.

Decomposition:
- Package clk_gate_pkg:
  - State encodings: GATED=0, SETTLE=1, WAIT_UP=2, ACTIVE=3, IDLE=4, WAIT_DN=5.
  - Requester index constants: REQ_ADAPTER=0, REQ_SB_MSG=1, REQ_SB_TRAIN=2.
- One sub-module, cg_down_counter: a loadable saturating down-counter with a zero flag, reused for the settle, idle and timeout phases.

Test Plan:
- Reset release, then i_wake_req=3'b001 at cycle 0 with ack returned 3 cycles after the enable: o_clk_gate_en=1 at cycle 1, ACTIVE after 8 settle cycles plus ack, o_wake_ack[0]=1 one cycle later. When the req drops, the ack drops one cycle later.
- In ACTIVE, raise i_gate_req with no requests for 16 cycles: o_clk_gate_en falls on cycle 17; ack falls 2 cycles later, and the state is GATED with o_busy=0.
- In IDLE at count 5, pulse i_wake_req[1]: returns to ACTIVE, o_clk_gate_en stays 1 throughout, o_wake_ack[1] follows the req.
- i_wake_req=3'b100 with i_clk_ungated_ack held 0: o_timeout_err pulses once after 256 cycles in WAIT_UP, o_clk_gate_en returns to 0, and retry begins on the next cycle. With CLK_GATE_DBG_EN, o_dbg_timeout_cnt=1.
- In WAIT_DN, assert i_wake_req[0] before the ack falls: o_clk_gate_en stays 0 until the ack falls and GATED is reached, then rises one cycle later.
- Assert i_rst_n=0 during ACTIVE: o_clk_gate_en, o_wake_ack and o_busy go to 0 asynchronously.
